pixel_capture: RTL and testbench

Front-end capture stage that sits directly upstream of ImageProc. It registers raw sensor pixels, frame-valid and line-valid, and gates capture to whole frames under start/stop control. It produces the pixel stream ImageProc consumes: oDATA/oDVAL plus X, Y and frame counters. Outputs are fully registered, so ImageProc sees clean, clock-aligned data with no combinational path from the sensor pins.

---
 rtl/pixel_capture.sv | 158 +++++++++++++++
 tb/tb_pixel_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture.sv
// pixel_capture: registered sensor front end feeding ImageProc.
// Registers raw pixels and FVAL/LVAL, gates capture to whole frames under
// iSTART/iEND control, and emits oDATA/oDVAL with X/Y/frame counters.
// Optional build macro PIXEL_CAPTURE_TEST_PATTERN_EN adds iTEST_MODE, which
// replaces sensor data with (X + Y) of the pixel being presented.
module pixel_capture #(
  parameter int DATA_W       = 12,
  parameter int COLUMN_WIDTH = 1280
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
  input  logic              iTEST_MODE,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [11:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic [31:0]       oFrame_Cont,
  output logic              oBUSY
);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME, GAP} state_t;

  localparam logic [11:0] X_LAST = 12'(COLUMN_WIDTH - 1);

  state_t            state;
  logic              stop_pending;
  logic [DATA_W-1:0] rDATA;
  logic              rFVAL, rLVAL, pFVAL;
  // position the next valid pixel will take inside the current frame
  logic [11:0]       nx;
  logic [15:0]       ny;

  logic              rise, fall, entry, valid;
  logic [11:0]       cx;
  logic [15:0]       cy;
  logic [DATA_W-1:0] pix;

  // stage 1: register sensor pins and keep previous FVAL for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rDATA <= '0;
      rFVAL <= 1'b0;
      rLVAL <= 1'b0;
      pFVAL <= 1'b0;
    end else begin
      rDATA <= iDATA;
      rFVAL <= iFVAL;
      rLVAL <= iLVAL;
      pFVAL <= rFVAL;
    end
  end

  // edge decode, frame entry and pixel qualification for this cycle
  always_comb begin
    rise  = rFVAL & ~pFVAL;
    fall  = ~rFVAL & pFVAL;
    // a pending stop in ARMED/GAP wins over a coinciding rise
    entry = rise & ~stop_pending & ((state == ARMED) || (state == GAP));
    // rFVAL gate keeps a stray LVAL on the fall cycle from leaking through
    valid = ((state == FRAME) || entry) & rFVAL & rLVAL;
    cx    = entry ? 12'd0 : nx;
    cy    = entry ? 16'd0 : ny;
    pix   = rDATA;
`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
    if (iTEST_MODE) pix = DATA_W'({5'd0, cx} + {1'b0, cy});
`endif
  end

  // capture control FSM with stop request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
    end else begin
      if (iEND) stop_pending <= 1'b1;
      case (state)
        IDLE: begin
          // stop requests while idle are meaningless; start+end cancels
          stop_pending <= 1'b0;
          if (iSTART && !iEND) state <= ARMED;
        end
        ARMED: begin
          if (stop_pending) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
          end else if (rise) begin
            state <= FRAME;
          end
        end
        FRAME: begin
          if (fall) begin
            if (stop_pending) begin
              state        <= IDLE;
              stop_pending <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (stop_pending) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
          end else if (rise) begin
            state <= FRAME;
          end
        end
        default: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
        end
      endcase
    end
  end

  // output stage: data, valid, coordinates and frame count, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oBUSY       <= 1'b0;
      nx          <= '0;
      ny          <= '0;
    end else begin
      oDVAL <= valid;
      oBUSY <= (state != IDLE);
      if (entry) oFrame_Cont <= oFrame_Cont + 32'd1;
      if (entry || valid) begin
        oX_Cont <= cx;
        oY_Cont <= cy;
      end
      if (valid) begin
        oDATA <= pix;
        if (cx == X_LAST) begin
          nx <= 12'd0;
          ny <= cy + 16'd1;
        end else begin
          nx <= cx + 12'd1;
          ny <= cy;
        end
      end else if (entry) begin
        nx <= 12'd0;
        ny <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture with COLUMN_WIDTH=4.
module tb_pixel_capture;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic          iFVAL = 1'b0, iLVAL = 1'b0, iSTART = 1'b0, iEND = 1'b0;
`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
  logic          iTEST_MODE = 1'b0;
`endif
  logic [DW-1:0] oDATA;
  logic          oDVAL, oBUSY;
  logic [11:0]   oX_Cont;
  logic [15:0]   oY_Cont;
  logic [31:0]   oFrame_Cont;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  int q_data[$], q_x[$], q_y[$], q_f[$], q_cyc[$], exp_cyc[$];

  pixel_capture #(.DATA_W(DW), .COLUMN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND),
`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
    .iTEST_MODE(iTEST_MODE),
`endif
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // log every valid output beat
  always @(negedge clk) begin
    if (oDVAL === 1'b1) begin
      q_data.push_back(int'(oDATA));
      q_x.push_back(int'(oX_Cont));
      q_y.push_back(int'(oY_Cont));
      q_f.push_back(int'(oFrame_Cont));
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    q_data.delete(); q_x.delete(); q_y.delete(); q_f.delete();
    q_cyc.delete(); exp_cyc.delete();
  endtask

  task automatic drv(input logic f, input logic l, input int d,
                     input logic s, input logic e);
    @(negedge clk);
    iFVAL = f; iLVAL = l; iDATA = DW'(d); iSTART = s; iEND = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    drv(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(3);
  endtask

  // one frame: 2 lines of 4 pixels (data base..base+7), LVAL rises with FVAL
  task automatic send_frame(input int base, input int start_at, input int end_at);
    int idx = 0;
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 4; p++) begin
        drv(1'b1, 1'b1, base + idx, idx == start_at, idx == end_at);
        exp_cyc.push_back(cyc + 2);
        idx++;
      end
      drv(1'b1, 1'b0, 0, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 0, 1'b0, 1'b0);
    end
    idle(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iFVAL = 0; iLVAL = 0; iDATA = '0; iSTART = 0; iEND = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (oDATA !== '0) $display("FAIL reset_data got=%0h want=0", oDATA); else passed++;
    if (oDVAL !== 1'b0) $display("FAIL reset_dval got=%b want=0", oDVAL); else passed++;
    if (oX_Cont !== '0) $display("FAIL reset_x got=%0d want=0", oX_Cont); else passed++;
    if (oY_Cont !== '0) $display("FAIL reset_y got=%0d want=0", oY_Cont); else passed++;
    if (oFrame_Cont !== '0) $display("FAIL reset_frame got=%0d want=0", oFrame_Cont); else passed++;
    if (oBUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", oBUSY); else passed++;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_logs();
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    checks++;
    if (oBUSY !== 1'b1) $display("FAIL basic_busy got=%b want=1", oBUSY); else passed++;
    send_frame(1, -1, -1);
    checks++;
    if (q_data.size() != 8) $display("FAIL basic_count got=%0d want=8", q_data.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        checks += 5;
        if (q_data[i] != i + 1) $display("FAIL basic_data[%0d] got=%0d want=%0d", i, q_data[i], i + 1); else passed++;
        if (q_x[i] != i % 4) $display("FAIL basic_x[%0d] got=%0d want=%0d", i, q_x[i], i % 4); else passed++;
        if (q_y[i] != i / 4) $display("FAIL basic_y[%0d] got=%0d want=%0d", i, q_y[i], i / 4); else passed++;
        if (q_f[i] != 1) $display("FAIL basic_frame[%0d] got=%0d want=1", i, q_f[i]); else passed++;
        if (q_cyc[i] != exp_cyc[i]) $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, q_cyc[i], exp_cyc[i]); else passed++;
      end
    end
  endtask

  task automatic test_midframe_start();
    do_reset();
    send_frame(50, 2, -1);
    checks++;
    if (q_data.size() != 0) $display("FAIL mid_partial got=%0d beats want=0", q_data.size()); else passed++;
    clear_logs();
    send_frame(20, -1, -1);
    checks++;
    if (q_data.size() != 8) $display("FAIL mid_count got=%0d want=8", q_data.size());
    else begin
      passed++;
      checks += 3;
      if (q_data[0] != 20) $display("FAIL mid_first got=%0d want=20", q_data[0]); else passed++;
      if (q_f[0] != 1) $display("FAIL mid_frame got=%0d want=1", q_f[0]); else passed++;
      if (q_data[7] != 27) $display("FAIL mid_last got=%0d want=27", q_data[7]); else passed++;
    end
  endtask

  task automatic test_stop_pending();
    do_reset();
    pulse_start();
    send_frame(11, -1, 5);
    checks += 4;
    if (q_data.size() != 8) $display("FAIL stop_count got=%0d want=8", q_data.size()); else passed++;
    if (q_data.size() == 8 && q_data[7] != 18) $display("FAIL stop_last got=%0d want=18", q_data[7]); else passed++;
    if (oBUSY !== 1'b0) $display("FAIL stop_busy got=%b want=0", oBUSY); else passed++;
    if (oFrame_Cont !== 32'd1) $display("FAIL stop_frame got=%0d want=1", oFrame_Cont); else passed++;
    clear_logs();
    send_frame(30, -1, -1);
    checks += 2;
    if (q_data.size() != 0) $display("FAIL stop_next got=%0d beats want=0", q_data.size()); else passed++;
    if (oFrame_Cont !== 32'd1) $display("FAIL stop_next_frame got=%0d want=1", oFrame_Cont); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (oBUSY !== 1'b0) $display("FAIL simul_busy got=%b want=0", oBUSY); else passed++;
    send_frame(40, -1, -1);
    checks += 2;
    if (q_data.size() != 0) $display("FAIL simul_capture got=%0d beats want=0", q_data.size()); else passed++;
    if (oFrame_Cont !== 32'd0) $display("FAIL simul_frame got=%0d want=0", oFrame_Cont); else passed++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, i + 1, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (oDVAL !== 1'b0) $display("FAIL rstmid_dval got=%b want=0", oDVAL); else passed++;
    if (oDATA !== '0) $display("FAIL rstmid_data got=%0d want=0", oDATA); else passed++;
    if (oX_Cont !== '0 || oY_Cont !== '0) $display("FAIL rstmid_xy got=%0d,%0d want=0,0", oX_Cont, oY_Cont); else passed++;
    if (oFrame_Cont !== '0 || oBUSY !== 1'b0) $display("FAIL rstmid_frame_busy got=%0d,%b want=0,0", oFrame_Cont, oBUSY); else passed++;
    drv(1'b1, 1'b1, 6, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 7, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 8, 1'b0, 1'b0);
    rst_n = 1'b1;
    clear_logs();
    drv(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(4);
    send_frame(60, -1, -1);
    checks++;
    if (q_data.size() != 0) $display("FAIL rstmid_nostart got=%0d beats want=0", q_data.size()); else passed++;
    clear_logs();
    pulse_start();
    send_frame(70, -1, -1);
    checks += 2;
    if (q_data.size() != 8) $display("FAIL rstmid_restart got=%0d want=8", q_data.size()); else passed++;
    if (oFrame_Cont !== 32'd1) $display("FAIL rstmid_restart_frame got=%0d want=1", oFrame_Cont); else passed++;
  endtask

`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
  task automatic test_pattern();
    int exp_tp[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
    do_reset();
    iTEST_MODE = 1'b1;
    pulse_start();
    send_frame(200, -1, -1);
    checks++;
    if (q_data.size() != 8) $display("FAIL tp_count got=%0d want=8", q_data.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_data[i] != exp_tp[i]) $display("FAIL tp_data[%0d] got=%0d want=%0d", i, q_data[i], exp_tp[i]); else passed++;
      end
    end
    iTEST_MODE = 1'b0;
  endtask
`endif

  initial begin
    idle(2);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_midframe_start();
    test_stop_pending();
    test_simultaneous();
    test_reset_midframe();
`ifdef PIXEL_CAPTURE_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
